// File: rtl/tester_ctrl_pkg.sv
// ============================================================================
// Module   : tester_ctrl_pkg
// Purpose  : Shared constants for the tester control AXI4-Lite slave. This
//            includes register offsets, response codes, the BURST_SIZE limit,
//            reset values and the byte-lane merge helpers.
// Options  : TESTER_CTRL_IRQ_EN (consumed by the regfile and the top level)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tester_ctrl_pkg;

    // Register byte offsets within the window.
    localparam logic [7:0] OFF_STATUS     = 8'h00;
    localparam logic [7:0] OFF_FINISHED   = 8'h04;
    localparam logic [7:0] OFF_DUT_CTRL   = 8'h08;
    localparam logic [7:0] OFF_BURST_SIZE = 8'h0C;

    // Word index of each register. This is the byte offset with bits [1:0] dropped.
    typedef enum logic [1:0] {
        REG_STATUS     = 2'd0,
        REG_FINISHED   = 2'd1,
        REG_DUT_CTRL   = 2'd2,
        REG_BURST_SIZE = 2'd3
    } reg_idx_e;

    // AXI response encodings.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The largest burst is 256 vectors. Writes of 0 or above 256 clamp to this value.
    localparam int unsigned BURST_MAX = 256;

    // Reset values.
    localparam logic [31:0] RST_DUT_CTRL   = 32'h0000_0000;
    localparam logic [8:0]  RST_BURST_SIZE = 9'd1;

    // Replace the bytes of old_v whose WSTRB lane is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Clamp a merged BURST_SIZE value into the range 1..256.
    function automatic logic [8:0] sat_burst(input logic [31:0] v);
        if ((v == 32'd0) || (v > BURST_MAX)) return 9'(BURST_MAX);
        return v[8:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tester_ctrl_regfile.sv
// ============================================================================
// Module   : tester_ctrl_regfile
// Purpose  : Register storage for the tester control block. This covers the
//            WSTRB merge, the go_start edge pulse, the FINISHED latch and the
//            optional interrupt.
// Options  : TESTER_CTRL_IRQ_EN adds irq_enable (STATUS bit1) and irq_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tester_ctrl_regfile
    import tester_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_idx_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic [1:0]  rd_idx_i,
    output logic [31:0] rd_data_o,
    input  logic        fsm_done_i,
    output logic        go_o,
    output logic        go_start_o,
    output logic [31:0] dut_ctrl_o,
`ifdef TESTER_CTRL_IRQ_EN
    output logic        irq_o,
`endif
    output logic [8:0]  burst_size_o
);

    logic        go_q, go_d;
    logic        go_start_q;
    logic        fin_q, fin_d;
    logic [31:0] dut_ctrl_q, dut_ctrl_d;
    logic [8:0]  burst_q, burst_d;
    logic        status_wr;
    logic        irq_en_q, irq_en_d;
`ifdef TESTER_CTRL_IRQ_EN
    logic        irq_q;
`endif

    assign status_wr = wr_en_i && (reg_idx_e'(wr_idx_i) == REG_STATUS);

    // Next-state for every register. A set from fsm_done takes priority over a clear from the go=0 write.
    always_comb begin
        go_d       = go_q;
        fin_d      = fin_q;
        dut_ctrl_d = dut_ctrl_q;
        burst_d    = burst_q;
        irq_en_d   = irq_en_q;
        if (status_wr && wstrb_i[0]) begin
            go_d = wdata_i[0];
`ifdef TESTER_CTRL_IRQ_EN
            irq_en_d = wdata_i[1];
`endif
        end
        if (wr_en_i && (reg_idx_e'(wr_idx_i) == REG_DUT_CTRL))
            dut_ctrl_d = strb_merge(dut_ctrl_q, wdata_i, wstrb_i);
        if (wr_en_i && (reg_idx_e'(wr_idx_i) == REG_BURST_SIZE))
            burst_d = sat_burst(strb_merge({23'd0, burst_q}, wdata_i, wstrb_i));
        if (fsm_done_i && go_q)
            fin_d = 1'b1;
        else if (status_wr && wstrb_i[0] && !wdata_i[0])
            fin_d = 1'b0;
    end

    // Register state. go_start fires on the edge where go moves from 0 to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            go_q       <= 1'b0;
            go_start_q <= 1'b0;
            fin_q      <= 1'b0;
            dut_ctrl_q <= RST_DUT_CTRL;
            burst_q    <= RST_BURST_SIZE;
            irq_en_q   <= 1'b0;
        end else begin
            go_q       <= go_d;
            go_start_q <= go_d && !go_q;
            fin_q      <= fin_d;
            dut_ctrl_q <= dut_ctrl_d;
            burst_q    <= burst_d;
            irq_en_q   <= irq_en_d;
        end
    end

`ifdef TESTER_CTRL_IRQ_EN
    // The interrupt is a registered copy of FINISHED gated by irq_enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= fin_q && irq_en_q;
    end
    assign irq_o = irq_q;
`endif

    // Read mux. Unused bits read as zero.
    always_comb begin
        rd_data_o = 32'd0;
        case (reg_idx_e'(rd_idx_i))
            REG_STATUS:     rd_data_o = {30'd0, irq_en_q, go_q};
            REG_FINISHED:   rd_data_o = {31'd0, fin_q};
            REG_DUT_CTRL:   rd_data_o = dut_ctrl_q;
            REG_BURST_SIZE: rd_data_o = {23'd0, burst_q};
            default:        rd_data_o = 32'd0;
        endcase
    end

    assign go_o         = go_q;
    assign go_start_o   = go_start_q;
    assign dut_ctrl_o   = dut_ctrl_q;
    assign burst_size_o = burst_q;

endmodule

`default_nettype wire

// File: rtl/tester_ctrl_axil_slave.sv
// ============================================================================
// Module   : tester_ctrl_axil_slave
// Purpose  : AXI4-Lite slave front end for the tester controller. It handles
//            the channel handshakes, address decode and responses. Register
//            storage lives in tester_ctrl_regfile.
// Options  : TESTER_CTRL_IRQ_EN adds the irq output and STATUS bit1
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tester_ctrl_axil_slave
    import tester_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          go,
    output logic                          go_start,
    input  logic                          fsm_done,
    output logic [31:0]                   dut_ctrl,
`ifdef TESTER_CTRL_IRQ_EN
    output logic                          irq,
`endif
    output logic [8:0]                    burst_size
);

    logic        awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic [31:0] rf_rdata;
    logic        wr_acc, rd_acc, wr_mapped, rd_mapped;
    logic        unused_addr_lsbs;

    // Only the first four words of the window are mapped. The byte-lane bits are don't-care.
    assign wr_mapped        = (S_AXI_AWADDR >> 4) == '0;
    assign rd_mapped        = (S_AXI_ARADDR >> 4) == '0;
    assign wr_acc           = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_acc           = arready_q && S_AXI_ARVALID;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel. The ready pulse is one cycle long and is only offered while no B response is pending.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
            if (wr_acc) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel. Data is captured at accept, so a write accepted on the same edge is not yet visible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'd0;
        end else begin
            arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (rd_acc) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= rd_mapped ? rf_rdata : 32'd0;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    tester_ctrl_regfile u_regfile (
        .clk_i        (ACLK),
        .rst_ni       (ARESETN),
        .wr_en_i      (wr_acc && wr_mapped),
        .wr_idx_i     (S_AXI_AWADDR[3:2]),
        .wdata_i      (S_AXI_WDATA[31:0]),
        .wstrb_i      (S_AXI_WSTRB),
        .rd_idx_i     (S_AXI_ARADDR[3:2]),
        .rd_data_o    (rf_rdata),
        .fsm_done_i   (fsm_done),
        .go_o         (go),
        .go_start_o   (go_start),
        .dut_ctrl_o   (dut_ctrl),
`ifdef TESTER_CTRL_IRQ_EN
        .irq_o        (irq),
`endif
        .burst_size_o (burst_size)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_tester_ctrl_axil_slave.sv
// ============================================================================
// Module   : tb_tester_ctrl_axil_slave
// Purpose  : Directed self-checking bench for tester_ctrl_axil_slave
// Options  : TESTER_CTRL_IRQ_EN selects the interrupt checks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tester_ctrl_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        go, go_start;
    logic        fsm_done = 1'b0;
    logic [31:0] dut_ctrl;
    logic [8:0]  burst_size;
`ifdef TESTER_CTRL_IRQ_EN
    logic        irq;
`endif

    int n_vec = 0;
    int n_err = 0;
    int gs_cnt = 0;

    tester_ctrl_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .go(go), .go_start(go_start), .fsm_done(fsm_done), .dut_ctrl(dut_ctrl),
`ifdef TESTER_CTRL_IRQ_EN
        .irq(irq),
`endif
        .burst_size(burst_size)
    );

    always #5 ACLK = ~ACLK;

    // Count go_start pulses, sampled away from the active edge.
    always @(negedge ACLK) if (go_start) gs_cnt <= gs_cnt + 1;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue_aw(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit pulse_done);
        bit seen;
        seen = 1'b0;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin seen = 1'b1; break; end
        end
        check_vec("aw_w_ready", {31'd0, seen}, 32'd1);
        if (pulse_done) fsm_done = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; fsm_done = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] r);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin seen = 1'b1; break; end
        end
        check_vec("b_valid", {31'd0, seen}, 32'd1);
        r = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic issue_ar(input logic [4:0] a);
        bit seen;
        seen = 1'b0;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin seen = 1'b1; break; end
        end
        check_vec("ar_ready", {31'd0, seen}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin seen = 1'b1; break; end
        end
        check_vec("r_valid", {31'd0, seen}, 32'd1);
        d = S_AXI_RDATA; r = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        issue_aw(a, d, s, 1'b0);
        wait_b(r);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        issue_ar(a);
        wait_r(d, r);
    endtask

    task automatic pulse_done();
        @(negedge ACLK); fsm_done = 1'b1;
        @(negedge ACLK); fsm_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_hs"}, {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                 S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
        check_vec({tag, "_resp"}, {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check_vec({tag, "_rdata"}, S_AXI_RDATA, 32'd0);
        check_vec({tag, "_go"}, {30'd0, go, go_start}, 32'd0);
        check_vec({tag, "_dut_ctrl"}, dut_ctrl, 32'd0);
        check_vec({tag, "_burst"}, {23'd0, burst_size}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rsp;
        logic [31:0] rd;
        int          gs0;

        // Reset state.
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // DUT_CTRL: a full-word write followed by a readback.
        axi_write(5'h08, 32'h5FFF_FFFC, 4'hF, rsp);
        check_vec("dutctrl_bresp", {30'd0, rsp}, 32'd0);
        check_vec("dutctrl_pin", dut_ctrl, 32'h5FFF_FFFC);
        axi_read(5'h08, rd, rsp);
        check_vec("dutctrl_rd", rd, 32'h5FFF_FFFC);
        check_vec("dutctrl_rresp", {30'd0, rsp}, 32'd0);

        // Byte-lane write: only lane 1 changes. The address LSBs are ignored.
        axi_write(5'h0A, 32'h0000_AB00, 4'h2, rsp);
        check_vec("strb_merge", dut_ctrl, 32'h5FFF_ABFC);

        // BURST_SIZE values and saturation.
        axi_write(5'h0C, 32'd10, 4'hF, rsp);
        check_vec("burst_10", {23'd0, burst_size}, 32'd10);
        axi_read(5'h0C, rd, rsp);
        check_vec("burst_10_rd", rd, 32'd10);
        axi_write(5'h0C, 32'd0, 4'hF, rsp);
        axi_read(5'h0C, rd, rsp);
        check_vec("burst_0_sat", rd, 32'd256);
        axi_write(5'h0C, 32'h1FF, 4'hF, rsp);
        axi_read(5'h0C, rd, rsp);
        check_vec("burst_1ff_sat", rd, 32'd256);
        axi_write(5'h0C, 32'd257, 4'hF, rsp);
        check_vec("burst_257_sat", {23'd0, burst_size}, 32'd256);
        axi_write(5'h0C, 32'd256, 4'hF, rsp);
        check_vec("burst_256", {23'd0, burst_size}, 32'd256);
        axi_write(5'h0C, 32'd1, 4'hF, rsp);
        check_vec("burst_1", {23'd0, burst_size}, 32'd1);

        // go and go_start, then FINISHED set and clear.
        gs0 = gs_cnt;
        axi_write(5'h00, 32'd1, 4'hF, rsp);
        repeat (3) @(negedge ACLK);
        check_vec("go_set", {31'd0, go}, 32'd1);
        check_vec("go_start_once", gs_cnt - gs0, 32'd1);
        gs0 = gs_cnt;
        axi_write(5'h00, 32'd1, 4'hF, rsp);
        repeat (3) @(negedge ACLK);
        check_vec("go_rewrite_nopulse", gs_cnt - gs0, 32'd0);
        axi_read(5'h04, rd, rsp);
        check_vec("finished_idle", rd, 32'd0);
        pulse_done();
        axi_read(5'h04, rd, rsp);
        check_vec("finished_set", rd, 32'd1);
        axi_write(5'h00, 32'd0, 4'hF, rsp);
        check_vec("go_clear", {31'd0, go}, 32'd0);
        axi_read(5'h04, rd, rsp);
        check_vec("finished_clear", rd, 32'd0);
        pulse_done();
        axi_read(5'h04, rd, rsp);
        check_vec("done_while_idle", rd, 32'd0);

        // fsm_done arrives on the same edge as a go=0 write. The set wins.
        axi_write(5'h00, 32'd1, 4'hF, rsp);
        issue_aw(5'h00, 32'd0, 4'hF, 1'b1);
        wait_b(rsp);
        check_vec("race_go", {31'd0, go}, 32'd0);
        axi_read(5'h04, rd, rsp);
        check_vec("race_finished", rd, 32'd1);
        axi_write(5'h00, 32'd0, 4'hF, rsp);
        axi_read(5'h04, rd, rsp);
        check_vec("race_cleanup", rd, 32'd0);

`ifdef TESTER_CTRL_IRQ_EN
        // The interrupt follows FINISHED when it is enabled.
        axi_write(5'h00, 32'd3, 4'hF, rsp);
        axi_read(5'h00, rd, rsp);
        check_vec("status_irq_en", rd, 32'd3);
        pulse_done();
        @(negedge ACLK);
        check_vec("irq_set", {31'd0, irq}, 32'd1);
        axi_write(5'h00, 32'd0, 4'hF, rsp);
        check_vec("irq_clear", {31'd0, irq}, 32'd0);
`else
        // Without the interrupt option, STATUS bit1 cannot be written.
        axi_write(5'h00, 32'd3, 4'hF, rsp);
        axi_read(5'h00, rd, rsp);
        check_vec("status_bit1_ro", rd, 32'd1);
        axi_write(5'h00, 32'd0, 4'hF, rsp);
`endif

        // Unmapped offset 0x14.
        axi_read(5'h14, rd, rsp);
        check_vec("unmapped_rresp", {30'd0, rsp}, 32'd2);
        check_vec("unmapped_rdata", rd, 32'd0);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, rsp);
        check_vec("unmapped_bresp", {30'd0, rsp}, 32'd2);
        check_vec("unmapped_nochg", dut_ctrl, 32'h5FFF_ABFC);
        check_vec("unmapped_nochg_b", {22'd0, go, burst_size}, 32'd1);

        // Read and write of DUT_CTRL accepted on the same edge. The read sees the old value.
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        check_vec("same_edge_ready", {30'd0, S_AXI_AWREADY, S_AXI_ARREADY}, 32'd3);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        wait_r(rd, rsp);
        check_vec("rw_pre_value", rd, 32'h5FFF_ABFC);
        wait_b(rsp);
        check_vec("rw_post_value", dut_ctrl, 32'h1234_5678);

        // Stalled responses, a blocked new request, then reset while waiting.
        issue_aw(5'h08, 32'hCAFE_F00D, 4'hF, 1'b0);
        issue_ar(5'h08);
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'd7; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check_vec("stall_hs", {28'd0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY,
                                   S_AXI_ARREADY}, 32'hC);
            check_vec("stall_rdata", S_AXI_RDATA, 32'hCAFE_F00D);
        end
        check_vec("stall_burst", {23'd0, burst_size}, 32'd1);
        #2 ARESETN = 1'b0;
        #1 check_reset_outputs("midreset");
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);
        check_vec("post_reset_idle", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
